sd_emmc_xfer_ctrl: RTL and testbench
====================================

Name: sd_emmc_xfer_ctrl

Overview:
- Sequences multi-block data transfers on the sd_clk side of the dual-clock AXI<->SD FIFO pair.
- For writes to the card, it pops words from the host-to-card FWFT FIFO into the SD data engine, block by block.
- For reads from the card, it pushes engine words into the card-to-host FIFO.
- It counts words and blocks, checks per-block completion and CRC status, and reports done, error and progress to the register block.

Parameters:
BLK_SIZE_W, 12, width of blk_size in bytes (max 2048).
BLK_CNT_W, 16, width of blk_count and blocks_done.
TIMEOUT, 65535, idle cycles allowed without progress in XFER or BLK_WAIT before a timeout error.

Ports:
sd_clk  in  1  SD-domain clock; only clock of the block.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle transfer request; sampled only in IDLE.
dir  in  1  0 = write to card (drain TX FIFO), 1 = read from card (fill RX FIFO); latched on start.
blk_size  in  BLK_SIZE_W  block size in bytes; latched on start.
blk_count  in  BLK_CNT_W  number of blocks; latched on start.
abort  in  1  cancel the transfer in progress.
tx_fifo_empty  in  1  EMPTY flag of the host-to-card FWFT FIFO.
tx_fifo_data  in  32  head word of the TX FIFO.
tx_fifo_rd_en  out  1  pop TX FIFO.
rx_fifo_full  in  1  FULL flag of the card-to-host FIFO.
rx_fifo_wr_en  out  1  push RX FIFO.
rx_fifo_data  out  32  word pushed into the RX FIFO.
eng_blk_start  out  1  one-cycle pulse: engine starts a block.
eng_tx_data  out  32  word to the engine.
eng_tx_valid  out  1  eng_tx_data is valid.
eng_tx_ready  in  1  engine accepts the word.
eng_rx_data  in  32  word from the engine.
eng_rx_valid  in  1  eng_rx_data is valid; cannot be back-pressured.
eng_blk_done  in  1  pulse: block CRC/busy phase is finished.
eng_crc_ok  in  1  CRC status; qualified by eng_blk_done.
busy  out  1  high in any state other than IDLE.
xfer_done  out  1  one-cycle pulse on successful completion.
xfer_err  out  1  one-cycle pulse on any error.
err_code  out  3  0 none, 1 bad config, 2 CRC, 3 timeout, 4 RX overrun, 5 abort, 6 short block; held until the next accepted start.
blocks_done  out  BLK_CNT_W  number of blocks completed with good CRC.

Behaviour:
- Reset: state IDLE; every output is 0, including err_code and blocks_done.
- IDLE, on start:
  - Config is invalid when blk_size==0, blk_size[1:0]!=0 or blk_count==0. Then err_code=1 and xfer_err pulses the next cycle; the block stays in IDLE.
  - Otherwise it latches dir, blk_size and blk_count, clears err_code and blocks_done, and moves to BLK_START.
- start while not IDLE is ignored.
- BLK_START (1 cycle):
  - eng_blk_start=1.
  - Word counter is loaded with blk_size>>2.
  - Next state is XFER.
- XFER, dir=0:
  - eng_tx_valid = !tx_fifo_empty; eng_tx_data = tx_fifo_data.
  - tx_fifo_rd_en = eng_tx_valid & eng_tx_ready (combinational, zero latency).
  - Each handshake decrements the word counter.
- XFER, dir=1:
  - eng_rx_valid & !rx_fifo_full gives rx_fifo_wr_en=1 and rx_fifo_data=eng_rx_data in the same cycle, and decrements the word counter.
  - eng_rx_valid & rx_fifo_full: word dropped, wr_en=0, ERR with code 4.
- XFER exit:
  - The handshake on the last word (counter==1) moves to BLK_WAIT.
  - eng_blk_done in XFER leads to ERR with code 6.
- BLK_WAIT:
  - On eng_blk_done with eng_crc_ok: blocks_done+1. If the new value equals blk_count, go to DONE; otherwise go to BLK_START.
  - On eng_blk_done with !eng_crc_ok: ERR with code 2.
- Timeout:
  - The counter clears on every word handshake and every state change.
  - It increments in XFER and BLK_WAIT.
  - Reaching TIMEOUT leads to ERR with code 3.
- DONE: xfer_done=1 for one cycle, then IDLE.
- ERR: xfer_err=1 for one cycle, then IDLE. err_code is registered on entry to ERR.
- abort, when not IDLE:
  - Highest priority.
  - Forces tx_fifo_rd_en, rx_fifo_wr_en and eng_tx_valid to 0 in the same cycle.
  - Next state is ERR with code 5.
- abort in IDLE is ignored.
- Simultaneous events: abort > overrun > short block > CRC > timeout.
- eng_rx_valid, eng_tx_ready and eng_blk_done outside their qualifying states are ignored.
- FIFO data is not flushed by this block; flushing is handled by the FIFO reset from the register block.

Decomposition:
- Package sd_emmc_xfer_pkg holds:
  - state enum: IDLE, BLK_START, XFER, BLK_WAIT, DONE, ERR;
  - err_code constants;
  - dir constants DIR_WR=0, DIR_RD=1.
- No sub-module; the timeout and word/block counters are inline.

Test Plan:
- TX, blk_size=512, blk_count=2, FIFO preloaded with 256 words, ready=1, crc_ok=1 on each blk_done:
  - exactly 2 eng_blk_start pulses and 128 rd_en per block, words in order;
  - blocks_done=2, then xfer_done pulse, busy falls the next cycle, err_code=0.
- TX with tx_fifo_empty and eng_tx_ready toggling pseudo-randomly, blk_size=64:
  - rd_en only when !empty & ready;
  - 16 pops total with no duplicate or lost word.
- RX, blk_size=64, rx_fifo_full raised at word 10:
  - wr_en=0 on that word;
  - xfer_err pulse with err_code=4 and blocks_done=0.
- TX, blk_count=3, crc_ok=0 on the 2nd blk_done: err_code=2, blocks_done=1, no third eng_blk_start.
- abort at word 50 of a 512-byte block:
  - same-cycle rd_en=0; next cycle ERR, then IDLE with err_code=5;
  - a following valid start completes normally and clears err_code.
- start with blk_size=6: err_code=1, busy never 1.
- TIMEOUT=100 with no eng_blk_done in BLK_WAIT: err_code=3 exactly 100 cycles after entering BLK_WAIT.

Source files
------------

// File: rtl/sd_emmc_xfer_pkg.sv
// Shared types and constants for the SD/eMMC multi-block transfer sequencer.
package sd_emmc_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BLK_START = 3'd1,
    XFER      = 3'd2,
    BLK_WAIT  = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } xfer_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CFG     = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam logic [2:0] ERR_ABORT   = 3'd5;
  localparam logic [2:0] ERR_SHORT   = 3'd6;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/sd_emmc_xfer_ctrl.sv
// sd_clk-side block sequencer: moves words between the AXI<->SD FIFOs and the
// SD data engine, counting words/blocks and reporting completion or failure.
module sd_emmc_xfer_ctrl
  import sd_emmc_xfer_pkg::*;
#(
  parameter int BLK_SIZE_W = 12,
  parameter int BLK_CNT_W  = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  sd_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [BLK_SIZE_W-1:0] blk_size,
  input  logic [BLK_CNT_W-1:0]  blk_count,
  input  logic                  abort,
  input  logic                  tx_fifo_empty,
  input  logic [31:0]           tx_fifo_data,
  output logic                  tx_fifo_rd_en,
  input  logic                  rx_fifo_full,
  output logic                  rx_fifo_wr_en,
  output logic [31:0]           rx_fifo_data,
  output logic                  eng_blk_start,
  output logic [31:0]           eng_tx_data,
  output logic                  eng_tx_valid,
  input  logic                  eng_tx_ready,
  input  logic [31:0]           eng_rx_data,
  input  logic                  eng_rx_valid,
  input  logic                  eng_blk_done,
  input  logic                  eng_crc_ok,
  output logic                  busy,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic [2:0]            err_code,
  output logic [BLK_CNT_W-1:0]  blocks_done
);

  localparam int WC_W  = BLK_SIZE_W - 2;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  xfer_state_e          state_r;
  logic                 dir_r;
  logic [WC_W-1:0]      blk_words_r;
  logic [WC_W-1:0]      word_cnt_r;
  logic [BLK_CNT_W-1:0] blk_count_r;
  logic [BLK_CNT_W-1:0] blocks_done_r;
  logic [TMO_W-1:0]     tmo_cnt_r;
  logic                 busy_r;
  logic                 xfer_done_r;
  logic                 xfer_err_r;
  logic                 eng_blk_start_r;
  logic [2:0]           err_code_r;

  logic                 xfer_wr_s;
  logic                 xfer_rd_s;
  logic                 abort_s;
  logic                 tx_valid_s;
  logic                 tx_hs_s;
  logic                 rx_hs_s;
  logic                 word_hs_s;
  logic                 overrun_s;
  logic                 tmo_hit_s;
  logic                 cfg_bad_s;
  logic [BLK_CNT_W-1:0] blocks_next_s;
  logic                 fail_s;
  logic [2:0]           fail_code_s;

  // FIFO/engine handshakes; abort squashes every data movement in the same cycle
  always_comb begin
    xfer_wr_s     = (state_r == XFER) && (dir_r == DIR_WR);
    xfer_rd_s     = (state_r == XFER) && (dir_r == DIR_RD);
    abort_s       = abort && (state_r != IDLE);
    tx_valid_s    = xfer_wr_s && !tx_fifo_empty && !abort;
    tx_hs_s       = tx_valid_s && eng_tx_ready;
    rx_hs_s       = xfer_rd_s && eng_rx_valid && !rx_fifo_full && !abort;
    overrun_s     = xfer_rd_s && eng_rx_valid && rx_fifo_full;
    word_hs_s     = tx_hs_s || rx_hs_s;
    tmo_hit_s     = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
    cfg_bad_s     = (blk_size == {BLK_SIZE_W{1'b0}}) || (blk_size[1:0] != 2'b00) ||
                    (blk_count == {BLK_CNT_W{1'b0}});
    blocks_next_s = blocks_done_r + BLK_CNT_W'(1'b1);
    eng_tx_valid  = tx_valid_s;
    eng_tx_data   = xfer_wr_s ? tx_fifo_data : 32'h0000_0000;
    tx_fifo_rd_en = tx_hs_s;
    rx_fifo_wr_en = rx_hs_s;
    rx_fifo_data  = xfer_rd_s ? eng_rx_data : 32'h0000_0000;
  end

  // Error arbitration: abort > overrun > short block > CRC > timeout
  always_comb begin
    fail_s      = 1'b1;
    fail_code_s = ERR_NONE;
    if (abort_s) begin
      fail_code_s = ERR_ABORT;
    end else if (overrun_s) begin
      fail_code_s = ERR_OVERRUN;
    end else if ((state_r == XFER) && eng_blk_done) begin
      fail_code_s = ERR_SHORT;
    end else if ((state_r == BLK_WAIT) && eng_blk_done && !eng_crc_ok) begin
      fail_code_s = ERR_CRC;
    end else if (tmo_hit_s && (((state_r == XFER) && !word_hs_s) ||
                               ((state_r == BLK_WAIT) && !eng_blk_done))) begin
      fail_code_s = ERR_TIMEOUT;
    end else begin
      fail_s      = 1'b0;
      fail_code_s = ERR_NONE;
    end
  end

  // Transfer FSM with inline word, block and idle-timeout counters
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_r         <= IDLE;
      dir_r           <= DIR_WR;
      blk_words_r     <= {WC_W{1'b0}};
      word_cnt_r      <= {WC_W{1'b0}};
      blk_count_r     <= {BLK_CNT_W{1'b0}};
      blocks_done_r   <= {BLK_CNT_W{1'b0}};
      tmo_cnt_r       <= {TMO_W{1'b0}};
      busy_r          <= 1'b0;
      xfer_done_r     <= 1'b0;
      xfer_err_r      <= 1'b0;
      eng_blk_start_r <= 1'b0;
      err_code_r      <= ERR_NONE;
    end else begin
      eng_blk_start_r <= 1'b0;
      xfer_done_r     <= 1'b0;
      xfer_err_r      <= 1'b0;
      if (fail_s) begin
        state_r    <= ERR;
        err_code_r <= fail_code_s;
        xfer_err_r <= 1'b1;
        tmo_cnt_r  <= {TMO_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            if (start && cfg_bad_s) begin
              err_code_r <= ERR_CFG;
              xfer_err_r <= 1'b1;
            end else if (start) begin
              dir_r           <= dir;
              blk_words_r     <= blk_size[BLK_SIZE_W-1:2];
              blk_count_r     <= blk_count;
              err_code_r      <= ERR_NONE;
              blocks_done_r   <= {BLK_CNT_W{1'b0}};
              eng_blk_start_r <= 1'b1;
              busy_r          <= 1'b1;
              state_r         <= BLK_START;
            end else begin
              state_r <= IDLE;
            end
          end
          BLK_START: begin
            word_cnt_r <= blk_words_r;
            tmo_cnt_r  <= {TMO_W{1'b0}};
            state_r    <= XFER;
          end
          XFER: begin
            if (word_hs_s) begin
              word_cnt_r <= word_cnt_r - WC_W'(1'b1);
              tmo_cnt_r  <= {TMO_W{1'b0}};
              if (word_cnt_r == WC_W'(1'b1)) begin
                state_r <= BLK_WAIT;
              end
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
            end
          end
          BLK_WAIT: begin
            if (eng_blk_done) begin
              blocks_done_r <= blocks_next_s;
              tmo_cnt_r     <= {TMO_W{1'b0}};
              if (blocks_next_s == blk_count_r) begin
                xfer_done_r <= 1'b1;
                state_r     <= DONE;
              end else begin
                eng_blk_start_r <= 1'b1;
                state_r         <= BLK_START;
              end
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
            end
          end
          DONE, ERR: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy          = busy_r;
  assign xfer_done     = xfer_done_r;
  assign xfer_err      = xfer_err_r;
  assign err_code      = err_code_r;
  assign blocks_done   = blocks_done_r;
  assign eng_blk_start = eng_blk_start_r;

endmodule

// File: tb/tb_sd_emmc_xfer_ctrl.sv
// Directed bench for sd_emmc_xfer_ctrl: FWFT TX FIFO model, simple engine model,
// hand-computed expectations checked with immediate assertions.
module tb_sd_emmc_xfer_ctrl;
  import sd_emmc_xfer_pkg::*;

  localparam int BLK_SIZE_W = 12;
  localparam int BLK_CNT_W  = 16;
  localparam int TIMEOUT    = 100;

  logic                  sd_clk = 1'b0;
  logic                  rst, start, dir, abort;
  logic [BLK_SIZE_W-1:0] blk_size;
  logic [BLK_CNT_W-1:0]  blk_count;
  logic                  tx_fifo_empty, tx_fifo_rd_en, rx_fifo_full, rx_fifo_wr_en;
  logic [31:0]           tx_fifo_data, rx_fifo_data, eng_tx_data, eng_rx_data;
  logic                  eng_blk_start, eng_tx_valid, eng_tx_ready, eng_rx_valid;
  logic                  eng_blk_done, eng_crc_ok, busy, xfer_done, xfer_err;
  logic [2:0]            err_code;
  logic [BLK_CNT_W-1:0]  blocks_done;

  sd_emmc_xfer_ctrl #(.BLK_SIZE_W(BLK_SIZE_W), .BLK_CNT_W(BLK_CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .sd_clk(sd_clk), .rst(rst), .start(start), .dir(dir), .blk_size(blk_size),
    .blk_count(blk_count), .abort(abort), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_rd_en(tx_fifo_rd_en), .rx_fifo_full(rx_fifo_full),
    .rx_fifo_wr_en(rx_fifo_wr_en), .rx_fifo_data(rx_fifo_data), .eng_blk_start(eng_blk_start),
    .eng_tx_data(eng_tx_data), .eng_tx_valid(eng_tx_valid), .eng_tx_ready(eng_tx_ready),
    .eng_rx_data(eng_rx_data), .eng_rx_valid(eng_rx_valid), .eng_blk_done(eng_blk_done),
    .eng_crc_ok(eng_crc_ok), .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .err_code(err_code), .blocks_done(blocks_done)
  );

  always #5 sd_clk = ~sd_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] txq[$];
  logic [31:0] exp_next;
  int pops, blk_starts, pops_at_2nd, done_pulses, err_pulses, bad_rd, order_err;
  int words_in_blk, wpb, dly, blk_issued, crc_bad_on, cyc_n, err_cyc, last_pop_cyc;
  int abort_at, abort_cyc, wr_ens, rx_bad, rx_sent, rx_full_at;
  bit tx_rand, rx_mode, rx_active, no_blk_done, busy_seen, abort_fired;
  logic abort_rd, abort_valid, full_wr, done_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_tx();
    if (tx_rand) begin
      tx_fifo_empty = (txq.size() == 0) || ($urandom_range(3) == 0);
      eng_tx_ready  = ($urandom_range(3) != 0);
    end else begin
      tx_fifo_empty = (txq.size() == 0);
      eng_tx_ready  = 1'b1;
    end
    tx_fifo_data = (txq.size() > 0) ? txq[0] : 32'h0000_0000;
  endtask

  // One clock: sample at negedge, update models, drive next inputs after posedge
  task automatic cyc();
    @(negedge sd_clk);
    cyc_n++;
    if (busy) busy_seen = 1'b1;
    if (eng_blk_start) begin
      if (blk_starts == 1) pops_at_2nd = pops;
      blk_starts++;
      rx_active = rx_mode;
    end
    if (xfer_done) begin done_pulses++; done_busy = busy; end
    if (xfer_err) begin err_pulses++; err_cyc = cyc_n; rx_active = 1'b0; end
    if (abort) begin abort_rd = tx_fifo_rd_en; abort_valid = eng_tx_valid; abort_cyc = cyc_n; end
    if (tx_fifo_rd_en) begin
      if (tx_fifo_empty || !eng_tx_ready) bad_rd++;
      if (tx_fifo_data !== exp_next) order_err++;
      exp_next++;
      pops++;
      last_pop_cyc = cyc_n;
      if (txq.size() > 0) void'(txq.pop_front());
      words_in_blk++;
      if (words_in_blk == wpb) begin words_in_blk = 0; dly = 3; end
    end
    if (rx_fifo_wr_en) begin
      if (rx_fifo_data !== 32'hB000_0000 + wr_ens) rx_bad++;
      wr_ens++;
    end
    if (eng_rx_valid && rx_fifo_full) full_wr = rx_fifo_wr_en;
    @(posedge sd_clk);
    #1;
    eng_blk_done = 1'b0;
    eng_crc_ok   = 1'b0;
    abort        = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0 && !no_blk_done) begin
        blk_issued++;
        eng_blk_done = 1'b1;
        eng_crc_ok   = (blk_issued != crc_bad_on);
      end
    end
    if (abort_at >= 0 && !abort_fired && pops == abort_at) begin
      abort = 1'b1;
      abort_fired = 1'b1;
    end
    drive_tx();
    eng_rx_valid = 1'b0;
    rx_fifo_full = 1'b0;
    if (rx_active && rx_sent < wpb) begin
      eng_rx_valid = 1'b1;
      eng_rx_data  = 32'hB000_0000 + rx_sent;
      rx_fifo_full = (rx_sent == rx_full_at);
      rx_sent++;
    end
  endtask

  task automatic clear();
    txq.delete();
    exp_next = 32'hA000_0000;
    pops = 0; blk_starts = 0; pops_at_2nd = -1; done_pulses = 0; err_pulses = 0;
    bad_rd = 0; order_err = 0; words_in_blk = 0; wpb = 16; dly = 0; blk_issued = 0;
    crc_bad_on = 0; err_cyc = -1; last_pop_cyc = -1; abort_at = -1; abort_cyc = -1;
    wr_ens = 0; rx_bad = 0; rx_sent = 0; rx_full_at = -1;
    tx_rand = 1'b0; rx_mode = 1'b0; rx_active = 1'b0; no_blk_done = 1'b0;
    busy_seen = 1'b0; abort_fired = 1'b0;
    abort_rd = 1'b1; abort_valid = 1'b1; full_wr = 1'b1; done_busy = 1'b0;
  endtask

  task automatic load_tx(input int n);
    for (int i = 0; i < n; i++) txq.push_back(32'hA000_0000 + i);
    drive_tx();
  endtask

  task automatic start_xfer(input logic d, input int size, input int cnt);
    dir       = d;
    blk_size  = BLK_SIZE_W'(size);
    blk_count = BLK_CNT_W'(cnt);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_pulses + err_pulses == 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("end_reached", (done_pulses + err_pulses) != 0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_n = 0;
    clear();
    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0; blk_size = '0; blk_count = '0;
    tx_fifo_empty = 1'b0; tx_fifo_data = 32'hDEAD_BEEF; eng_tx_ready = 1'b1;
    rx_fifo_full = 1'b0; eng_rx_data = 32'h1234_5678; eng_rx_valid = 1'b1;
    eng_blk_done = 1'b0; eng_crc_ok = 1'b0;
    repeat (3) @(posedge sd_clk);
    @(negedge sd_clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_code", err_code, 3'd0);
    chk("rst_blocks_done", blocks_done, 16'd0);
    chk("rst_pulses", {xfer_done, xfer_err, eng_blk_start}, 3'b000);
    chk("rst_fifo_ctrl", {tx_fifo_rd_en, rx_fifo_wr_en, eng_tx_valid}, 3'b000);
    chk("rst_data", eng_tx_data | rx_fifo_data, 32'h0);
    @(posedge sd_clk); #1;
    rst = 1'b0; eng_rx_valid = 1'b0;

    // TX, 2 x 512-byte blocks
    clear(); wpb = 128; load_tx(256);
    start_xfer(DIR_WR, 512, 2);
    wait_end(2000);
    chk("t1_done", done_pulses, 1);
    chk("t1_err", err_pulses, 0);
    chk("t1_blk_starts", blk_starts, 2);
    chk("t1_pops", pops, 256);
    chk("t1_pops_blk1", pops_at_2nd, 128);
    chk("t1_order", order_err, 0);
    chk("t1_busy_at_done", done_busy, 1'b1);
    chk("t1_blocks_done", blocks_done, 16'd2);
    @(negedge sd_clk);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_err_code", err_code, 3'd0);
    @(posedge sd_clk); #1;

    // TX with random empty/ready
    clear(); tx_rand = 1'b1; wpb = 16; load_tx(16);
    start_xfer(DIR_WR, 64, 1);
    wait_end(1000);
    tx_rand = 1'b0;
    chk("t2_done", done_pulses, 1);
    chk("t2_pops", pops, 16);
    chk("t2_bad_rd", bad_rd, 0);
    chk("t2_order", order_err, 0);
    chk("t2_fifo_drained", txq.size(), 0);
    chk("t2_blocks_done", blocks_done, 16'd1);

    // RX overrun at word 10
    clear(); rx_mode = 1'b1; wpb = 16; rx_full_at = 9; drive_tx();
    start_xfer(DIR_RD, 64, 1);
    wait_end(500);
    rx_mode = 1'b0;
    chk("t3_err", err_pulses, 1);
    chk("t3_err_code", err_code, ERR_OVERRUN);
    chk("t3_blocks_done", blocks_done, 16'd0);
    chk("t3_wr_ens", wr_ens, 9);
    chk("t3_wr_on_full", full_wr, 1'b0);
    chk("t3_rx_data", rx_bad, 0);

    // CRC failure on second of three blocks
    clear(); wpb = 16; crc_bad_on = 2; load_tx(48);
    start_xfer(DIR_WR, 64, 3);
    wait_end(1000);
    repeat (5) cyc();
    chk("t4_err_code", err_code, ERR_CRC);
    chk("t4_blocks_done", blocks_done, 16'd1);
    chk("t4_blk_starts", blk_starts, 2);
    chk("t4_done", done_pulses, 0);
    chk("t4_pops", pops, 32);

    // Abort at word 50 of a 512-byte block
    clear(); wpb = 128; abort_at = 50; load_tx(128);
    start_xfer(DIR_WR, 512, 1);
    wait_end(500);
    chk("t5_abort_rd_en", abort_rd, 1'b0);
    chk("t5_abort_valid", abort_valid, 1'b0);
    chk("t5_err_latency", err_cyc - abort_cyc, 1);
    chk("t5_pops", pops, 50);
    @(negedge sd_clk);
    chk("t5_busy_fall", busy, 1'b0);
    chk("t5_err_code", err_code, ERR_ABORT);
    @(posedge sd_clk); #1;

    // Normal transfer after abort clears err_code
    clear(); wpb = 16; load_tx(16);
    chk("t6_err_code_held", err_code, ERR_ABORT);
    start_xfer(DIR_WR, 64, 1);
    chk("t6_err_code_cleared", err_code, ERR_NONE);
    wait_end(500);
    chk("t6_done", done_pulses, 1);
    chk("t6_blocks_done", blocks_done, 16'd1);
    chk("t6_pops", pops, 16);

    // Bad configuration: blk_size=6
    clear();
    start_xfer(DIR_WR, 6, 1);
    repeat (3) cyc();
    chk("t7_err", err_pulses, 1);
    chk("t7_err_code", err_code, ERR_CFG);
    chk("t7_busy_never", busy_seen, 1'b0);
    chk("t7_blk_starts", blk_starts, 0);

    // Timeout in BLK_WAIT
    clear(); wpb = 16; no_blk_done = 1'b1; load_tx(16);
    start_xfer(DIR_WR, 64, 1);
    wait_end(400);
    chk("t8_err_code", err_code, ERR_TIMEOUT);
    chk("t8_latency", err_cyc - last_pop_cyc, 101);
    chk("t8_pops", pops, 16);
    chk("t8_blocks_done", blocks_done, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
